// File: rtl/axi_stream_writer.sv
// axi_stream_writer: turns a command (address, beat count) plus an AXI-Stream into AXI4 INCR write bursts.
// Bursts are capped by MAX_BURST_LEN and 4 KB pages; only one burst is in flight at a time.
module axi_stream_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  done,
    output logic                  error,
    output logic                  busy
);
    localparam int SIZE = $clog2(STRB_WIDTH);
    localparam int EW   = ADDR_WIDTH < 12 ? 12 : ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic [15:0]           rem, rem_n;
    logic [7:0]            beat_cnt;
    logic [8:0]            cur_beats, beats;
    logic [EW-1:0]         addr_ext;
    logic [12:0]           to_bound;
    logic [16:0]           lim_a, lim;
    logic                  cmd_fire, w_fire, b_fire;
    logic                  unused_ok;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = state == DATA && s_axis_tvalid && !rst;
    assign s_axis_tready = state == DATA && m_axi_wready && !rst;
    assign m_axi_wlast   = state == DATA && beat_cnt == m_axi_awlen;
    assign m_axi_bready  = state == RESP;
    assign cmd_ready     = state == IDLE && !rst;
    assign busy          = state != IDLE;
    assign unused_ok     = ^{m_axi_bid, addr_ext, lim};

    always_comb begin
        cmd_fire  = cmd_valid && cmd_ready;
        w_fire    = m_axi_wvalid && m_axi_wready;
        b_fire    = m_axi_bready && m_axi_bvalid;
        cur_beats = {1'b0, m_axi_awlen} + 9'd1;
        state_n   = state;
        addr_n    = addr;
        rem_n     = rem;
        if (state == IDLE && cmd_fire) begin
            addr_n  = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            rem_n   = cmd_len;
            state_n = cmd_len != 16'd0 ? ADDR : IDLE;
        end
        if (state == ADDR && m_axi_awready)
            state_n = DATA;
        if (w_fire && m_axi_wlast)
            state_n = RESP;
        if (b_fire) begin
            addr_n  = addr + ADDR_WIDTH'(32'(cur_beats) << SIZE);
            rem_n   = rem - 16'(cur_beats);
            state_n = rem_n != 16'd0 ? ADDR : IDLE;
        end
        // next burst size, computed from the address/length the burst will start from
        addr_ext = EW'(addr_n);
        to_bound = (13'd4096 - {1'b0, addr_ext[11:0]}) >> SIZE;
        lim_a    = 17'(rem_n) < 17'(to_bound) ? 17'(rem_n) : 17'(to_bound);
        lim      = lim_a < 17'(MAX_BURST_LEN) ? lim_a : 17'(MAX_BURST_LEN);
        beats    = lim[8:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            rem           <= '0;
            beat_cnt      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            rem           <= rem_n;
            beat_cnt      <= state_n != DATA ? 8'd0 : beat_cnt + 8'(w_fire);
            m_axi_awvalid <= state_n == ADDR;
            done          <= (cmd_fire && cmd_len == 16'd0) || (b_fire && rem_n == 16'd0);
            error         <= cmd_fire ? 1'b0 : error | (b_fire && m_axi_bresp != 2'b00);
            if (state_n == ADDR && state != ADDR) begin
                m_axi_awaddr <= addr_n;
                m_axi_awlen  <= 8'(beats - 9'd1);
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_writer.sv
// tb_axi_stream_writer: directed bench acting as AXI slave and stream source, checked by immediate assertions.
module tb_axi_stream_writer;
    logic        clk, rst;
    logic [15:0] cmd_addr, cmd_len;
    logic        cmd_valid, cmd_ready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [7:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        done, error, busy;

    int          n_chk, n_fail;
    int          seq;
    int          aw_word;
    logic [31:0] ram [0:2047];

    axi_stream_writer dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .done(done), .error(error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] l);
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_cmd", busy, l != 16'd0);
        chk("error_cleared", error, 0);
    endtask

    task automatic aw_phase(input logic [15:0] exp_addr, input logic [7:0] exp_len);
        int g = 0;
        while (!m_axi_awvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("aw_wait", m_axi_awvalid, 1);
        chk("awaddr", m_axi_awaddr, exp_addr);
        chk("awlen", m_axi_awlen, exp_len);
        chk("awsize", m_axi_awsize, 3'd2);
        chk("awburst", m_axi_awburst, 2'b01);
        chk("awid", m_axi_awid, 8'd0);
        chk("awcache", m_axi_awcache, 4'b0011);
        chk("cmd_ready_busy", cmd_ready, 0);
        s_axis_tvalid = 1'b1; m_axi_wready = 1'b1; cmd_valid = 1'b1;
        #1 chk("wvalid_not_data", m_axi_wvalid, 0);
        chk("tready_not_data", s_axis_tready, 0);
        chk("cmd_ready_wait", cmd_ready, 0);
        s_axis_tvalid = 1'b0; m_axi_wready = 1'b0; cmd_valid = 1'b0;
        aw_word = int'(exp_addr >> 2);
        @(negedge clk);
        chk("awvalid_hold", m_axi_awvalid, 1);
        chk("awaddr_hold", m_axi_awaddr, exp_addr);
        chk("awlen_hold", m_axi_awlen, exp_len);
        m_axi_awready = 1'b1;
        @(negedge clk);
        m_axi_awready = 1'b0;
        chk("awvalid_drop", m_axi_awvalid, 0);
    endtask

    task automatic w_phase(input int n, input int total, input bit gaps);
        int i = 0;
        int g = 0;
        while (i < n && g < 500) begin
            s_axis_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi_wready  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = 32'hD000_0000 + 32'(seq);
            #1;
            if (s_axis_tvalid && m_axi_wready) begin
                chk("wvalid", m_axi_wvalid, 1);
                chk("tready", s_axis_tready, 1);
                chk("wdata", m_axi_wdata, 32'hD000_0000 + 32'(seq));
                chk("wstrb", m_axi_wstrb, 4'hF);
                chk("wlast", m_axi_wlast, i == total - 1);
                ram[aw_word + i] = m_axi_wdata;
                seq++;
                i++;
            end else begin
                chk("wvalid_pass", m_axi_wvalid, s_axis_tvalid);
                chk("tready_pass", s_axis_tready, m_axi_wready);
            end
            @(negedge clk);
            g++;
        end
        chk("w_beats_done", i, n);
        s_axis_tvalid = 1'b0; m_axi_wready = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] resp, input bit last, input bit exp_err);
        chk("bready", m_axi_bready, 1);
        chk("no_aw_before_b", m_axi_awvalid, 0);
        m_axi_bvalid = 1'b1; m_axi_bresp = resp;
        @(negedge clk);
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        chk("done_pulse", done, last);
        if (last) begin
            chk("error_at_done", error, exp_err);
            chk("busy_at_done", busy, 0);
            chk("cmd_ready_at_done", cmd_ready, 1);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
        end
    endtask

    task automatic check_ram(input int word, input int seq0, input int n);
        for (int k = 0; k < n; k++)
            chk("ram_word", ram[word + k], 32'hD000_0000 + 32'(seq0 + k));
    endtask

    initial begin
        n_chk = 0; n_fail = 0; seq = 0; aw_word = 0;
        rst = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1 chk("cmd_ready_after_rst", cmd_ready, 1);
        @(negedge clk);

        // single short burst
        send_cmd(16'h0000, 16'd4);
        aw_phase(16'h0000, 8'd3);
        w_phase(4, 4, 0);
        b_phase(2'b00, 1, 0);
        check_ram(0, 0, 4);

        // three bursts, SLVERR on the second
        send_cmd(16'h0000, 16'd40);
        aw_phase(16'h0000, 8'd15); w_phase(16, 16, 0); b_phase(2'b00, 0, 0);
        aw_phase(16'h0040, 8'd15); w_phase(16, 16, 0); b_phase(2'b10, 0, 0);
        aw_phase(16'h0080, 8'd7);  w_phase(8, 8, 0);   b_phase(2'b00, 1, 1);
        check_ram(0, 4, 40);

        // 4 KB split; accepting the command clears the sticky error
        send_cmd(16'h0FF0, 16'd8);
        aw_phase(16'h0FF0, 8'd3); w_phase(4, 4, 0); b_phase(2'b00, 0, 0);
        aw_phase(16'h1000, 8'd3); w_phase(4, 4, 0); b_phase(2'b00, 1, 0);
        check_ram(16'h0FF0 >> 2, 44, 8);

        // random gaps on both sides, unaligned start address
        send_cmd(16'h0203, 16'd20);
        aw_phase(16'h0200, 8'd15); w_phase(16, 16, 1); b_phase(2'b00, 0, 0);
        aw_phase(16'h0240, 8'd3);  w_phase(4, 4, 1);   b_phase(2'b00, 1, 0);
        check_ram(16'h0200 >> 2, 52, 20);

        // zero-length command
        send_cmd(16'h0500, 16'd0);
        chk("len0_done", done, 1);
        chk("len0_awvalid", m_axi_awvalid, 0);
        @(negedge clk);
        chk("len0_done_clear", done, 0);

        // reset after two of eight beats
        send_cmd(16'h0300, 16'd8);
        aw_phase(16'h0300, 8'd7);
        w_phase(2, 8, 0);
        s_axis_tvalid = 1'b1; m_axi_wready = 1'b1; rst = 1'b1;
        #1 chk("midrst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_wvalid", m_axi_wvalid, 0);
        chk("abort_tready", s_axis_tready, 0);
        chk("abort_wlast", m_axi_wlast, 0);
        chk("abort_awvalid", m_axi_awvalid, 0);
        chk("abort_bready", m_axi_bready, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        s_axis_tvalid = 1'b0; m_axi_wready = 1'b0;
        @(negedge clk);
        chk("abort_done_later", done, 0);
        send_cmd(16'h0400, 16'd1);
        aw_phase(16'h0400, 8'd0);
        w_phase(1, 1, 0);
        b_phase(2'b00, 1, 0);
        check_ram(16'h0400 >> 2, 74, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
